// File: rtl/cacheline_adaptor.sv
// Bridges a cache's full-line read/write port to a fixed-width burst memory, one line at a time.
// Optional line-transfer counters are enabled by defining CACHELINE_ADAPTOR_PERF_CNT_EN.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic               read_o,
  output logic               write_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
  output logic [31:0]        rd_lines_o,
  output logic [31:0]        wr_lines_o,
`endif
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                        state;
  state_e                        state_next;
  logic [CNT_W-1:0]              cnt;
  logic [ADDR_W-1:0]             addr_q;
  logic [BEATS-1:0][BURST_W-1:0] wline_q;
  logic [BEATS-1:0][BURST_W-1:0] rline_q;
  logic                          last_beat;

  assign last_beat = resp_i && (cnt == LAST_BEAT);
  assign address_o = addr_q;
  assign line_o    = rline_q;

  // NOTE: every output and next-state term gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
    burst_o    = '0;
    unique case (state)
      IDLE: begin
        if (write_i)     state_next = WRITE;
        else if (read_i) state_next = READ;
      end
      READ: begin
        read_o = 1'b1;
        if (last_beat) state_next = DONE;
      end
      WRITE: begin
        write_o = 1'b1;
        burst_o = wline_q[cnt];
        if (last_beat) state_next = DONE;
      end
      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the line buffers are reset because line_o must read zero after reset; this is not free, but it is required here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (write_i || read_i) begin
            addr_q <= address_i & ALIGN_MASK;
            cnt    <= '0;
          end
          if (write_i) wline_q <= line_i;
        end
        READ: begin
          if (resp_i) begin
            rline_q[cnt] <= burst_i;
            cnt          <= last_beat ? '0 : cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (resp_i) cnt <= last_beat ? '0 : cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
  // Counters step on the edge entering DONE, so the new value is visible in the resp_o cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_lines_o <= '0;
      wr_lines_o <= '0;
    end else begin
      if (state == READ && last_beat)  rd_lines_o <= rd_lines_o + 32'd1;
      if (state == WRITE && last_beat) wr_lines_o <= wr_lines_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios plus randomized traffic against a
// transaction-level model (beats-remaining count and shift-in line accumulator).
module tb_cacheline_adaptor;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               read_i, write_i;
  logic [ADDR_W-1:0]  address_i;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o, read_o, write_o;
  logic [ADDR_W-1:0]  address_o;
  logic [BURST_W-1:0] burst_o;
  logic [BURST_W-1:0] burst_i;
  logic               resp_i;
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
  logic [31:0]        rd_lines, wr_lines;
`endif

  cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .address_o (address_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
    .rd_lines_o(rd_lines),
    .wr_lines_o(wr_lines),
`endif
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- memory responder ----------------
  logic [BURST_W-1:0] beat_q[$];
  bit                 stall_q[$];
  int unsigned        stall_pct = 0;
  bit                 noise_en  = 1'b0;

  initial begin
    resp_i  = 1'b0;
    burst_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (read_o || write_o) begin
        if (stall_q.size() > 0) resp_i = stall_q.pop_front();
        else                    resp_i = ($urandom_range(0, 99) >= stall_pct);
        if (read_o && resp_i && beat_q.size() > 0) burst_i = beat_q.pop_front();
        else                                       burst_i = {$urandom, $urandom};
      end else begin
        resp_i  = noise_en && ($urandom_range(0, 3) == 0);
        burst_i = {$urandom, $urandom};
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef enum int {K_NONE, K_READ, K_WRITE} kind_e;
  kind_e             m_kind  = K_NONE;
  int                m_left  = 0;
  bit                m_done  = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [LINE_W-1:0] m_wline = '0;
  logic [LINE_W-1:0] m_acc   = '0;
  logic [LINE_W-1:0] m_line  = '0;
  logic [31:0]       m_rd    = '0;
  logic [31:0]       m_wr    = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_kind = K_NONE; m_left = 0; m_done = 1'b0;
        m_addr = '0; m_wline = '0; m_acc = '0; m_line = '0;
        m_rd = '0; m_wr = '0;
      end else if (m_done) begin
        m_done = 1'b0;
        m_kind = K_NONE;
      end else if (m_kind == K_NONE) begin
        if (write_i || read_i) begin
          m_kind = write_i ? K_WRITE : K_READ;
          m_left = BEATS;
          m_addr = address_i - (address_i % ADDR_W'(LINE_W / 8));
          if (write_i) m_wline = line_i;
        end
      end else if (resp_i) begin
        if (m_kind == K_READ) m_acc = {burst_i, m_acc[LINE_W-1:BURST_W]};
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          if (m_kind == K_READ) begin
            m_line = m_acc;
            m_rd++;
          end else begin
            m_wr++;
          end
        end
      end
    end
  end

  // ---------------- compare process and monitors ----------------
  logic [BURST_W-1:0] wr_beats[$];
  int                 rd_o_seen  = 0;
  int                 resp_seen  = 0;
  logic [ADDR_W-1:0]  last_addr  = '0;

  initial begin
    forever begin
      @(negedge clk);
      check("read_o", read_o, m_kind == K_READ && !m_done);
      check("write_o", write_o, m_kind == K_WRITE && !m_done);
      check("resp_o", resp_o, m_done);
      if (m_kind != K_NONE && !m_done) check("address_o", address_o, m_addr);
      if (m_kind == K_WRITE && !m_done)
        check("burst_o", burst_o, BURST_W'(m_wline >> ((BEATS - m_left) * BURST_W)));
      if (!(m_kind == K_READ && !m_done)) check("line_o", line_o, m_line);
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
      check("rd_lines_o", rd_lines, m_rd);
      check("wr_lines_o", wr_lines, m_wr);
`endif
      if (write_o && resp_i) wr_beats.push_back(burst_o);
      if (read_o) rd_o_seen++;
      if (resp_o) resp_seen++;
      if (read_o || write_o) last_addr = address_o;
    end
  end

  // ---------------- driver ----------------
  task automatic run_txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] l, input bit scramble, output int cycles);
    read_i = rd; write_i = wr; address_i = a; line_i = l;
    cycles = 1;
    while (resp_o !== 1'b1 && cycles < 500) begin
      @(posedge clk);
      #1;
      cycles++;
      if (scramble) begin
        address_i = $urandom;
        line_i    = rand_line();
      end
    end
    check("txn_completed", resp_o, 1'b1);
    @(posedge clk);
    #1;
    read_i = 1'b0; write_i = 1'b0;
  endtask

  localparam logic [LINE_W-1:0] RD_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [LINE_W-1:0] WR_LINE = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

  initial begin
    int                cyc;
    logic [LINE_W-1:0] wl;
    logic [BURST_W-1:0] b[4];

    rst_n = 1'b0; read_i = 1'b0; write_i = 1'b0; address_i = '0; line_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_o", read_o, 1'b0);
    check("rst_write_o", write_o, 1'b0);
    check("rst_resp_o", resp_o, 1'b0);
    check("rst_line_o", line_o, '0);
    check("rst_address_o", address_o, '0);
    check("rst_burst_o", burst_o, '0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read, back-to-back beats.
    resp_seen = 0;
    beat_q = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 1'b0, cyc);
    check("rd_latency", cyc, 6);
    check("rd_line", line_o, RD_LINE);
    check("rd_addr", last_addr, 32'h0000_1220);
    check("rd_resp_count", resp_seen, 1);

    // Write-back then allocate on the very next IDLE cycle; inputs scrambled mid-write.
    wr_beats.delete();
    wl = rand_line();
    run_txn(1'b0, 1'b1, 32'h0000_2057, wl, 1'b1, cyc);
    check("wb_line_o_kept", line_o, RD_LINE);
    check("wb_beat_count", wr_beats.size(), 4);
    for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
    beat_q = '{b[0], b[1], b[2], b[3]};
    run_txn(1'b1, 1'b0, 32'h0000_2057, '0, 1'b0, cyc);
    check("alloc_latency", cyc, 6);
    check("alloc_no_extra_write", wr_beats.size(), 4);
    check("alloc_line", line_o, {b[3], b[2], b[1], b[0]});
    check("alloc_addr", last_addr, 32'h0000_2040);

    // Write with a three-cycle stall after the first beat.
    wr_beats.delete();
    resp_seen = 0;
    stall_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    run_txn(1'b0, 1'b1, 32'h8000_0040, WR_LINE, 1'b0, cyc);
    check("stall_latency", cyc, 9);
    check("stall_beat_count", wr_beats.size(), 4);
    if (wr_beats.size() == 4) begin
      check("stall_beat0", wr_beats[0], 64'hAAAA_AAAA_AAAA_AAAA);
      check("stall_beat1", wr_beats[1], 64'hBBBB_BBBB_BBBB_BBBB);
      check("stall_beat2", wr_beats[2], 64'hCCCC_CCCC_CCCC_CCCC);
      check("stall_beat3", wr_beats[3], 64'hDDDD_DDDD_DDDD_DDDD);
    end
    check("stall_resp_count", resp_seen, 1);
    check("stall_addr", last_addr, 32'h8000_0040);

    // Read and write requested together: write wins.
    wr_beats.delete();
    rd_o_seen = 0;
    run_txn(1'b1, 1'b1, 32'h0000_3000, rand_line(), 1'b0, cyc);
    check("both_no_read_o", rd_o_seen, 0);
    check("both_write_beats", wr_beats.size(), 4);

    // Asynchronous reset after two read beats.
    beat_q = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202, 64'h0303_0303_0303_0303};
    read_i = 1'b1; address_i = 32'h0000_4444;
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_read_o", read_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_read_o", read_o, 1'b0);
    check("async_rst_line_o", line_o, '0);
    check("async_rst_address_o", address_o, '0);
    read_i = 1'b0;
    beat_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat_q = '{64'h5555_0000_0000_0001, 64'h5555_0000_0000_0002,
               64'h5555_0000_0000_0003, 64'h5555_0000_0000_0004};
    run_txn(1'b1, 1'b0, 32'h0000_4444, '0, 1'b0, cyc);
    check("post_rst_latency", cyc, 6);
    check("post_rst_line", line_o, {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
                                    64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001});

    // Two more reads and two writes since reset: 3 reads, 2 writes in total.
    run_txn(1'b1, 1'b0, $urandom, '0, 1'b0, cyc);
    run_txn(1'b0, 1'b1, $urandom, rand_line(), 1'b0, cyc);
    run_txn(1'b1, 1'b0, $urandom, '0, 1'b0, cyc);
    run_txn(1'b0, 1'b1, $urandom, rand_line(), 1'b0, cyc);
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
    check("perf_rd_lines", rd_lines, 32'd3);
    check("perf_wr_lines", wr_lines, 32'd2);
`endif

    // Randomized traffic with memory stalls and resp_i noise while idle/done.
    stall_pct = 30;
    noise_en  = 1'b1;
    for (int t = 0; t < 150; t++) begin
      int unsigned k;
      k = $urandom_range(0, 19);
      run_txn((k < 10), (k == 0) || (k >= 10), $urandom, rand_line(),
              1'($urandom_range(0, 1)), cyc);
      check("rand_min_latency", cyc >= BEATS + 2, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    noise_en = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
